// File: rtl/data_arrays_banked_pipe.sv
// data_arrays_banked_pipe
//
// Instruction-cache data array built from NUM_BANKS word-interleaved banks.
// Each bank holds one word per (set, way, row) and has one read and one
// write port. Reads come from the tag/hit logic. Refill writes a full row
// (one word per bank) per beat.
//
// The read result is registered. A single skid entry behind the output
// register absorbs the word already in flight when downstream stalls, so
// o_r_ready depends only on registered state and never on i_out_ready.
//
// Optional feature macro: DATA_ARRAYS_PARITY_EN
//   When defined, every stored word carries an even-parity bit. The output
//   o_parity_err travels with o_valid/o_data, including through the skid.
//   Forwarded collision words always report 0.
//
// Ports:
//   clk, arst_n      clock, asynchronous active-low reset
//   i_halt_all       freeze all state; both readies forced low
//   i_flush          drop buffered read data and any read accepted this cycle
//   i_r_*            read request (valid/ready, set, way, word offset)
//   i_w_*            row write (valid/ready, set, way, row, per-bank mask,
//                    packed data; bank k at [k*WORD_WIDTH +: WORD_WIDTH])
//   o_valid, o_data  registered read result, handshaked by i_out_ready
//   o_parity_err     stored-parity mismatch (only with DATA_ARRAYS_PARITY_EN)
module data_arrays_banked_pipe #(
  parameter int SET_BITS      = 4,
  parameter int NUM_WAYS      = 4,
  parameter int B_OFFSET_BITS = 4,
  parameter int NUM_BANKS     = 4,
  parameter int WORD_WIDTH    = 20
) (
  input  logic                                      clk,
  input  logic                                      arst_n,
  input  logic                                      i_halt_all,
  input  logic                                      i_flush,
  input  logic                                      i_r_valid,
  output logic                                      o_r_ready,
  input  logic [SET_BITS-1:0]                       i_r_set,
  input  logic [$clog2(NUM_WAYS)-1:0]               i_r_way,
  input  logic [B_OFFSET_BITS-1:0]                  i_r_offset,
  input  logic                                      i_w_valid,
  output logic                                      o_w_ready,
  input  logic [SET_BITS-1:0]                       i_w_set,
  input  logic [$clog2(NUM_WAYS)-1:0]               i_w_way,
  input  logic [B_OFFSET_BITS-$clog2(NUM_BANKS)-1:0] i_w_row,
  input  logic [NUM_BANKS-1:0]                      i_w_mask,
  input  logic [NUM_BANKS*WORD_WIDTH-1:0]           i_w_data,
  output logic                                      o_valid,
  output logic [WORD_WIDTH-1:0]                     o_data,
  input  logic                                      i_out_ready
`ifdef DATA_ARRAYS_PARITY_EN
  ,
  output logic                                      o_parity_err
`endif
);

  localparam int WAY_BITS  = $clog2(NUM_WAYS);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = B_OFFSET_BITS - BANK_BITS;
  localparam int ADDR_BITS = SET_BITS + WAY_BITS + ROW_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                  rd_accept;
  logic                  wr_accept;
  logic [BANK_BITS-1:0]  r_bank;
  logic [ROW_BITS-1:0]   r_row;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS-1:0]  w_addr;
  logic                  fwd_hit;
  logic [WORD_WIDTH-1:0] rd_word;

  logic [WORD_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [WORD_WIDTH-1:0] w_word     [NUM_BANKS];

  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  skid_full;
  logic [WORD_WIDTH-1:0] skid_data;

  // Low-order offset bits pick the bank, so consecutive words of a line
  // land in different banks.
  assign r_bank = i_r_offset[BANK_BITS-1:0];
  assign r_row  = i_r_offset[B_OFFSET_BITS-1:BANK_BITS];
  assign r_addr = {i_r_set, i_r_way, r_row};
  assign w_addr = {i_w_set, i_w_way, i_w_row};

  // Ready is forced low in reset and derived only from registered state
  // plus halt. The skid guarantees room for the word accepted this cycle.
  assign o_r_ready = arst_n & ~i_halt_all & ~skid_full;
  assign o_w_ready = ~i_halt_all;

  assign rd_accept = i_r_valid & o_r_ready;
  assign wr_accept = i_w_valid & o_w_ready;

`ifdef DATA_ARRAYS_PARITY_EN
  logic bank_rpar [NUM_BANKS];
  logic rd_perr;
  logic out_perr;
  logic skid_perr;
`endif

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    assign w_word[k] = i_w_data[k*WORD_WIDTH +: WORD_WIDTH];

    always_ff @(posedge clk) begin
      if (wr_accept && i_w_mask[k]) begin
        mem[w_addr] <= w_word[k];
      end
    end

    assign bank_rdata[k] = mem[r_addr];

`ifdef DATA_ARRAYS_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_accept && i_w_mask[k]) begin
        par_mem[w_addr] <= ^w_word[k];
      end
    end

    assign bank_rpar[k] = par_mem[r_addr];
`endif
  end

  // The array read is combinational, so a write landing on the same edge is
  // not yet visible. When the write hits the word being read, bypass it.
  always_comb begin
    fwd_hit = wr_accept & (w_addr == r_addr) & i_w_mask[r_bank];
    rd_word = fwd_hit ? w_word[r_bank] : bank_rdata[r_bank];
  end

`ifdef DATA_ARRAYS_PARITY_EN
  always_comb begin
    rd_perr = 1'b0;
    if (!fwd_hit) begin
      rd_perr = (^bank_rdata[r_bank]) ^ bank_rpar[r_bank];
    end
  end
`endif

  // Output register plus one skid entry, kept in FIFO order. The skid only
  // fills while the output is stalled, and it always drains into the output
  // before any new word can get there.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (!i_halt_all) begin
      if (i_flush) begin
        out_valid <= 1'b0;
        skid_full <= 1'b0;
      end else if (!out_valid || i_out_ready) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          skid_full <= 1'b0;
        end else if (rd_accept) begin
          out_valid <= 1'b1;
          out_data  <= rd_word;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_accept) begin
        skid_full <= 1'b1;
        skid_data <= rd_word;
      end
    end
  end

`ifdef DATA_ARRAYS_PARITY_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_perr  <= 1'b0;
      skid_perr <= 1'b0;
    end else if (!i_halt_all && !i_flush) begin
      if (!out_valid || i_out_ready) begin
        if (skid_full) begin
          out_perr <= skid_perr;
        end else if (rd_accept) begin
          out_perr <= rd_perr;
        end else begin
          out_perr <= 1'b0;
        end
      end else if (rd_accept) begin
        skid_perr <= rd_perr;
      end
    end
  end

  assign o_parity_err = out_perr;
`endif

  assign o_valid = out_valid;
  assign o_data  = out_data;

  // A stalled output must hold its word.
  a_stall_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (out_valid && !i_out_ready && !i_flush) |=> (out_valid && $stable(out_data)));

  // The skid never holds a word while the output register is empty.
  a_skid_order: assert property (@(posedge clk) disable iff (!arst_n)
    skid_full |-> out_valid);

endmodule

// File: tb/tb_data_arrays_banked_pipe.sv
module tb_data_arrays_banked_pipe;
  localparam int SB = 4;
  localparam int NW = 4;
  localparam int OB = 4;
  localparam int NB = 4;
  localparam int WW = 20;
  localparam int WB = 2;
  localparam int RB = 2;

  logic            clk;
  logic            arst_n;
  logic            i_halt_all;
  logic            i_flush;
  logic            i_r_valid;
  logic            o_r_ready;
  logic [SB-1:0]   i_r_set;
  logic [WB-1:0]   i_r_way;
  logic [OB-1:0]   i_r_offset;
  logic            i_w_valid;
  logic            o_w_ready;
  logic [SB-1:0]   i_w_set;
  logic [WB-1:0]   i_w_way;
  logic [RB-1:0]   i_w_row;
  logic [NB-1:0]   i_w_mask;
  logic [NB*WW-1:0] i_w_data;
  logic            o_valid;
  logic [WW-1:0]   o_data;
  logic            i_out_ready;
`ifdef DATA_ARRAYS_PARITY_EN
  logic            o_parity_err;
`endif

  data_arrays_banked_pipe #(
    .SET_BITS(SB), .NUM_WAYS(NW), .B_OFFSET_BITS(OB), .NUM_BANKS(NB), .WORD_WIDTH(WW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_halt_all(i_halt_all), .i_flush(i_flush),
    .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_set(i_r_set),
    .i_r_way(i_r_way), .i_r_offset(i_r_offset),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_set(i_w_set),
    .i_w_way(i_w_way), .i_w_row(i_w_row), .i_w_mask(i_w_mask), .i_w_data(i_w_data),
    .o_valid(o_valid), .o_data(o_data), .i_out_ready(i_out_ready)
`ifdef DATA_ARRAYS_PARITY_EN
    , .o_parity_err(o_parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] d;
    logic          p;
  } item_t;

  int n_chk = 0;
  int n_fail = 0;
  item_t exp_q[$];

  // Reference model: plain line storage indexed [set][way][word offset].
  logic [WW-1:0] mdl     [16][4][16];
  bit            mdl_bad [16][4][16];

  item_t pend_item;
  bit    pend_push = 0;
  bit    prev_halt = 0;
  logic            held_v;
  logic [WW-1:0]   held_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Stimulus side: when a read is accepted, work out the word it must return
  // from the line model, then apply any accepted write to the model.
  always @(negedge clk) begin
    int off;
    logic [RB-1:0] wrow;
    pend_push = 0;
    if (arst_n && !i_halt_all) begin
      if (i_r_valid && o_r_ready && !i_flush) begin
        off = int'(i_r_offset);
        if (i_w_valid && o_w_ready && i_w_set == i_r_set && i_w_way == i_r_way &&
            (off / NB) == int'(i_w_row) && i_w_mask[off % NB]) begin
          pend_item.d = i_w_data[(off % NB)*WW +: WW];
          pend_item.p = 1'b0;
        end else begin
          pend_item.d = mdl[i_r_set][i_r_way][off];
          pend_item.p = mdl_bad[i_r_set][i_r_way][off];
        end
        pend_push = 1;
      end
      if (i_w_valid && o_w_ready) begin
        wrow = i_w_row;
        for (int k = 0; k < NB; k++) begin
          if (i_w_mask[k]) begin
            mdl[i_w_set][i_w_way][int'(wrow)*NB + k] = i_w_data[k*WW +: WW];
            mdl_bad[i_w_set][i_w_way][int'(wrow)*NB + k] = 1'b0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (pend_push && arst_n) exp_q.push_back(pend_item);
  end

  // Monitor: compares whatever the DUT presents against the queue head and
  // retires entries on consume or flush.
  always @(negedge clk) begin
    if (arst_n) begin
      check("o_valid_vs_model", o_valid, (exp_q.size() != 0));
      if (o_valid && exp_q.size() != 0) begin
        check("o_data", o_data, exp_q[0].d);
`ifdef DATA_ARRAYS_PARITY_EN
        check("o_parity_err", o_parity_err, exp_q[0].p);
`endif
      end
      if (i_halt_all) begin
        check("halt_r_ready", o_r_ready, 1'b0);
        check("halt_w_ready", o_w_ready, 1'b0);
        if (prev_halt) begin
          check("halt_o_valid_hold", o_valid, held_v);
          check("halt_o_data_hold", o_data, held_d);
        end
      end else begin
        check("o_r_ready", o_r_ready, (exp_q.size() < 2));
        check("o_w_ready", o_w_ready, 1'b1);
        if (i_flush) exp_q.delete();
        else if (o_valid && i_out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_halt = i_halt_all;
      held_v = o_valid;
      held_d = o_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_r_valid = 0;
    i_w_valid = 0;
    i_flush = 0;
    i_halt_all = 0;
  endtask

  task automatic set_read(input int s, input int w, input int off);
    i_r_valid = 1;
    i_r_set = SB'(s);
    i_r_way = WB'(w);
    i_r_offset = OB'(off);
  endtask

  task automatic set_write(input int s, input int w, input int r,
                           input logic [NB-1:0] m, input logic [NB*WW-1:0] d);
    i_w_valid = 1;
    i_w_set = SB'(s);
    i_w_way = WB'(w);
    i_w_row = RB'(r);
    i_w_mask = m;
    i_w_data = d;
  endtask

  function automatic logic [NB*WW-1:0] rand_row();
    logic [NB*WW-1:0] d;
    for (int k = 0; k < NB; k++) d[k*WW +: WW] = WW'($urandom);
    return d;
  endfunction

  task automatic do_reset();
    arst_n = 0;
    repeat (2) tick();
    check("reset_o_valid", o_valid, 1'b0);
    check("reset_o_data", o_data, '0);
    check("reset_o_r_ready", o_r_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    arst_n = 1;
    tick();
  endtask

  initial begin
    idle();
    i_out_ready = 1;
    i_r_set = 0; i_r_way = 0; i_r_offset = 0;
    i_w_set = 0; i_w_way = 0; i_w_row = 0; i_w_mask = 0; i_w_data = 0;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        for (int o = 0; o < 16; o++) begin
          mdl[s][w][o] = '0;
          mdl_bad[s][w][o] = 0;
        end
    do_reset();

    // Fill every row so each later read has a defined expected value.
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        for (int r = 0; r < 4; r++) begin
          set_write(s, w, r, 4'hF, rand_row());
          tick();
        end
    idle();
    tick();

    // Known row, then back-to-back reads across its four banks.
    set_write(3, 2, 1, 4'hF, {20'h44444, 20'h33333, 20'h22222, 20'h11111});
    tick();
    idle();
    for (int o = 4; o < 8; o++) begin
      set_read(3, 2, o);
      tick();
    end
    idle();
    repeat (3) tick();

    // Stall: two words fit (output + skid); the third must wait.
    i_out_ready = 0;
    set_read(3, 2, 5);
    tick();
    set_read(3, 2, 6);
    tick();
    set_read(3, 2, 7);
    tick();
    check("stall_r_ready_low", o_r_ready, 1'b0);
    idle();
    i_out_ready = 1;
    repeat (4) tick();

    // Same-edge write/read collision: mask hits bank 1, then misses it.
    set_write(5, 1, 2, 4'b0010, {20'h0, 20'h0, 20'hABCDE, 20'h0});
    set_read(5, 1, 9);
    tick();
    idle();
    tick();
    check("collision_fwd", o_data, 20'hABCDE);
    set_write(5, 1, 2, 4'b0001, {20'h0, 20'h0, 20'h12345, 20'h0});
    set_read(5, 1, 9);
    tick();
    idle();
    tick();
    check("collision_masked", o_data, 20'hABCDE);
    repeat (2) tick();

    // Flush with a word in the output and a read accepted the same cycle.
    i_out_ready = 0;
    set_read(3, 2, 4);
    tick();
    set_read(3, 2, 5);
    i_flush = 1;
    tick();
    idle();
    check("flush_o_valid", o_valid, 1'b0);
    // Flush with output and skid both full.
    set_read(3, 2, 6);
    tick();
    set_read(3, 2, 7);
    tick();
    idle();
    i_flush = 1;
    tick();
    idle();
    i_out_ready = 1;
    repeat (2) tick();
    set_read(3, 2, 7);
    tick();
    idle();
    repeat (2) tick();

    // Halt while output valid and downstream ready; a write during halt
    // must not reach the array.
    set_read(3, 2, 4);
    tick();
    idle();
    i_halt_all = 1;
    set_write(3, 2, 1, 4'hF, rand_row());
    repeat (5) tick();
    idle();
    tick();
    set_read(3, 2, 4);
    tick();
    set_read(3, 2, 7);
    tick();
    idle();
    repeat (3) tick();

    // Randomised traffic concentrated on a few sets to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(2, 0) != 0) set_read($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(15, 0));
      if ($urandom_range(9, 0) < 3)
        set_write($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                  NB'($urandom), rand_row());
      i_out_ready = ($urandom_range(9, 0) < 7);
      i_flush = ($urandom_range(39, 0) == 0);
      i_halt_all = ($urandom_range(19, 0) == 0);
      tick();
    end
    idle();
    i_out_ready = 1;
    repeat (4) tick();

`ifdef DATA_ARRAYS_PARITY_EN
    // Flip one stored bit behind the array's back; the read must flag it.
    dut.g_bank[1].mem[8'({4'd6, 2'd1, 2'd0})][0] = ~dut.g_bank[1].mem[8'({4'd6, 2'd1, 2'd0})][0];
    mdl[6][1][1][0] = ~mdl[6][1][1][0];
    mdl_bad[6][1][1] = 1;
    set_read(6, 1, 1);
    tick();
    idle();
    tick();
    check("parity_err_flag", o_parity_err, 1'b1);
    repeat (2) tick();
`endif

    // Asynchronous reset with output and skid full.
    i_out_ready = 0;
    set_read(2, 3, 3);
    tick();
    set_read(2, 3, 8);
    tick();
    idle();
    #2;
    arst_n = 0;
    #1;
    check("async_rst_o_valid", o_valid, 1'b0);
    check("async_rst_o_data", o_data, '0);
    check("async_rst_r_ready", o_r_ready, 1'b0);
    exp_q.delete();
    tick();
    @(negedge clk);
    arst_n = 1;
    i_out_ready = 1;
    tick();
    set_read(2, 3, 8);
    tick();
    set_read(3, 2, 6);
    tick();
    idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_arrays_banked_pipe.md
Name: data_arrays_banked_pipe

Overview:
Parametrised successor data array for the instruction cache.
- Holds NUM_BANKS word-interleaved storage banks, each 1-read/1-write and inferred inside the block.
- Read port: valid/ready request side, plus a registered output with a 1-entry skid so downstream stalls never drop words.
- Write port: takes a full row (one word per bank) per beat, with a per-bank write mask and same-cycle read-after-write forwarding.
- Sits between the tag/hit logic (reads) and the refill engine (writes).

Parameters:
SET_BITS, 4, set index width
NUM_WAYS, 4, ways per set (power of 2, ≥2)
B_OFFSET_BITS, 4, word offset within line (words per line = 2^B_OFFSET_BITS)
NUM_BANKS, 4, interleave factor (power of 2, 2..2^B_OFFSET_BITS); bank = offset[log2(NUM_BANKS)-1:0]
WORD_WIDTH, 20, bits per word

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_halt_all  in  1  freeze all state; no accepts, no consumes
i_flush  in  1  drop in-flight/buffered read data
i_r_valid  in  1  read request valid
o_r_ready  out  1  read request ready
i_r_set  in  SET_BITS  read set
i_r_way  in  log2(NUM_WAYS)  read way
i_r_offset  in  B_OFFSET_BITS  read word offset
i_w_valid  in  1  write valid
o_w_ready  out  1  write ready (= ~i_halt_all)
i_w_set  in  SET_BITS  write set
i_w_way  in  log2(NUM_WAYS)  write way
i_w_row  in  B_OFFSET_BITS-log2(NUM_BANKS)  row within line
i_w_mask  in  NUM_BANKS  per-bank write enable
i_w_data  in  NUM_BANKS*WORD_WIDTH  bank k uses bits [k*WORD_WIDTH +: WORD_WIDTH]
o_valid  out  1  output word valid
o_data  out  WORD_WIDTH  output word
i_out_ready  in  1  downstream accepts o_data

Behaviour:
- Reset (arst_n low, async): o_valid=0, o_data=0, skid empty, o_r_ready=0 while in reset. Array contents are not reset.
- Read accept: i_r_valid & o_r_ready at a rising edge.
  - o_r_ready = ~i_halt_all & ~skid_full. It is registered-state only, with no combinational path from i_out_ready.
  - Bank address = {set, way, offset[B_OFFSET_BITS-1:log2(NUM_BANKS)]}.
- Latency: a read accepted at edge N gives o_valid=1 and o_data = word after edge N.
- Output/skid, evaluated per edge when not halted:
  - If the output is empty or consumed (o_valid & i_out_ready): output ← skid if skid is full, else the new word if accepted, else empty.
  - If the output is stalled (o_valid & ~i_out_ready) and a word is accepted: word → skid, skid_full=1.
  - Order is strictly FIFO; at most 2 words are buffered.
  - o_data is stable while o_valid & ~i_out_ready.
- Write: i_w_valid & o_w_ready updates every bank with i_w_mask[k]=1 at the edge. Mask bits that are 0 leave the bank unchanged.
- Collision: a read and a write accepted at the same edge, with matching set/way/row, where the read's bank mask bit is 1, return the new write data. Mask bit 0 returns the old data.
- i_flush (sampled at edge, not halted):
  - o_valid←0 and skid emptied.
  - A read accepted in the same cycle is discarded.
  - Writes are unaffected.
- i_halt_all:
  - All registers hold; o_r_ready=0, o_w_ready=0.
  - i_out_ready and i_flush are ignored.
  - o_valid/o_data are held.
- Reset mid-operation: buffered words are lost; the first accept after reset release behaves as from idle.

Optional Feature:
DATA_ARRAYS_PARITY_EN
- Defined:
  - Each stored word carries one even-parity bit, computed on write.
  - Adds output o_parity_err (1 bit), aligned with o_valid/o_data and buffered through the skid alongside the data.
  - o_parity_err=1 when the stored parity mismatches the read word. Forwarded collision words always report 0.
  - Reset value 0.
- Undefined: no parity storage and no o_parity_err port.

Test Plan:
- Write row set=3, way=2, row=1, mask=4'b1111, data words 0x11111/0x22222/0x33333/0x44444; read offsets 4..7 back-to-back with i_out_ready=1 → o_valid each cycle after accept, data 0x11111..0x44444 in order, o_r_ready stays 1.
- Hold i_out_ready=0, issue 3 reads → 2 accepted (output+skid), o_r_ready=0 after the second. Raise i_out_ready → words emerge in order, o_r_ready returns 1 the cycle after the skid drains.
- Same-cycle write (mask=4'b0010, bank1 data 0xABCDE) and read of bank1 at the same row → o_data=0xABCDE. Repeat with mask=4'b0001 → old bank1 value.
- i_flush with output and skid full, plus a read accepted the same cycle → o_valid=0 next cycle, no stale words ever appear; a subsequent read returns correct data.
- i_halt_all for 5 cycles while o_valid=1 and i_out_ready=1 → o_data/o_valid unchanged, both readies 0, and a write presented during halt leaves the array unchanged.
- Assert arst_n low with the skid full → o_valid=0, o_data=0 immediately (asynchronously). With DATA_ARRAYS_PARITY_EN, corrupt one stored bit via backdoor → o_parity_err=1 with that word.
